// File: rtl/osd_dii_pkg.sv
// Shared DII packet definitions for the debug event packetizer:
// flag-field layout, event type/subtype codes and the packetizer FSM states.
package osd_dii_pkg;

  localparam logic [1:0] TYPE_EVENT       = 2'b10;
  localparam logic [3:0] SUBTYPE_OVERFLOW = 4'h5;

  localparam int FLAG_TYPE_MSB = 15;
  localparam int FLAG_TYPE_LSB = 14;
  localparam int FLAG_SUB_MSB  = 13;
  localparam int FLAG_SUB_LSB  = 10;

  typedef enum logic [2:0] {
    IDLE,
    DEST,
    SRC,
    FLAGS,
    PAYLOAD,
    OVF_PAYLOAD
  } state_t;

  function automatic logic [15:0] make_flags(input logic [3:0] sub);
    logic [15:0] f;
    f = '0;
    f[FLAG_TYPE_MSB:FLAG_TYPE_LSB] = TYPE_EVENT;
    f[FLAG_SUB_MSB:FLAG_SUB_LSB]   = sub;
    return f;
  endfunction

endpackage

// File: rtl/osd_event_overflow_ctr.sv
// Saturating count of events the source had to discard.
// A drop arriving in the same cycle as the clear is kept, so the count restarts at 1.
module osd_event_overflow_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= {15'h0, i_inc};
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'h1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/osd_event_packetizer.sv
// Packs one parallel debug event into a DII packet (dest, src, flags, payload)
// for a ring router local input. Optional drop reporting: OSD_EVENT_PACKETIZER_OVERFLOW_EN.
//
// state       | meaning
// IDLE        | no flit pending; accepts an event (or starts an overflow packet)
// DEST        | destination flit presented
// SRC         | source (own id) flit presented
// FLAGS       | flags flit presented; last when the event has no payload
// PAYLOAD     | payload word r_cnt presented
// OVF_PAYLOAD | single overflow-count payload flit presented
module osd_event_packetizer
  import osd_dii_pkg::*;
#(
  parameter int MAX_PAYLOAD = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [9:0]                         id,
  input  logic [9:0]                         dest,
  input  logic [3:0]                         event_type_sub,
  input  logic [16*MAX_PAYLOAD-1:0]          event_data,
  input  logic [$clog2(MAX_PAYLOAD+1)-1:0]   event_len,
  input  logic                               event_valid,
`ifdef OSD_EVENT_PACKETIZER_OVERFLOW_EN
  input  logic                               event_drop,
`endif
  output logic                               event_ready,
  output logic [15:0]                        out_data,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int LW = $clog2(MAX_PAYLOAD + 1);

  state_t                   r_state;
  logic [15:0]              r_data;
  logic                     r_valid;
  logic                     r_last;
  logic [3:0]               r_sub;
  logic [16*MAX_PAYLOAD-1:0] r_payload;
  logic [LW-1:0]            r_len;
  logic [LW-1:0]            r_cnt;

  logic                     w_fire;
  logic [LW-1:0]            w_cnt_inc;
  logic [LW-1:0]            w_len_clamp;
  logic [15:0]              w_next_word;

  assign w_fire      = r_valid & out_ready;
  assign w_cnt_inc   = r_cnt + LW'(1);
  assign w_len_clamp = (event_len > LW'(MAX_PAYLOAD)) ? LW'(MAX_PAYLOAD) : event_len;
  assign w_next_word = r_payload[16*int'(w_cnt_inc) +: 16];

`ifdef OSD_EVENT_PACKETIZER_OVERFLOW_EN
  logic        r_ovf;
  logic [15:0] w_ovf_cnt;
  logic        w_ovf_pending;

  osd_event_overflow_ctr u_ovf_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (event_drop),
    .i_clr ((r_state == OVF_PAYLOAD) & w_fire),
    .o_cnt (w_ovf_cnt)
  );

  assign w_ovf_pending = (w_ovf_cnt != 16'h0);
  // A pending overflow report blocks new events until it has been sent.
  assign event_ready   = !rst & (r_state == IDLE) & !w_ovf_pending;
`else
  assign event_ready   = !rst & (r_state == IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
      r_sub     <= '0;
      r_payload <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
`ifdef OSD_EVENT_PACKETIZER_OVERFLOW_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
`ifdef OSD_EVENT_PACKETIZER_OVERFLOW_EN
          if (w_ovf_pending) begin
            r_state <= DEST;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_data  <= {6'h0, dest};
            r_sub   <= SUBTYPE_OVERFLOW;
            r_len   <= LW'(1);
            r_ovf   <= 1'b1;
          end else
`endif
          if (event_valid) begin
            r_state   <= DEST;
            r_valid   <= 1'b1;
            r_last    <= 1'b0;
            r_data    <= {6'h0, dest};
            r_sub     <= event_type_sub;
            r_payload <= event_data;
            r_len     <= w_len_clamp;
`ifdef OSD_EVENT_PACKETIZER_OVERFLOW_EN
            r_ovf     <= 1'b0;
`endif
          end
        end
        DEST: if (w_fire) begin
          r_state <= SRC;
          r_data  <= {6'h0, id};
        end
        SRC: if (w_fire) begin
          r_state <= FLAGS;
          r_data  <= make_flags(r_sub);
          r_last  <= (r_len == '0);
        end
        FLAGS: if (w_fire) begin
          if (r_len == '0) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
          end else begin
`ifdef OSD_EVENT_PACKETIZER_OVERFLOW_EN
            if (r_ovf) begin
              r_state <= OVF_PAYLOAD;
              r_data  <= w_ovf_cnt;
              r_last  <= 1'b1;
            end else
`endif
            begin
              r_state <= PAYLOAD;
              r_cnt   <= '0;
              r_data  <= r_payload[15:0];
              r_last  <= (r_len == LW'(1));
            end
          end
        end
        PAYLOAD: if (w_fire) begin
          if (w_cnt_inc == r_len) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_data <= w_next_word;
            r_last <= ((w_cnt_inc + LW'(1)) == r_len);
          end
        end
        OVF_PAYLOAD: if (w_fire) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_data  <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_data  <= '0;
        end
      endcase
    end
  end

  assign out_data  = r_data;
  assign out_last  = r_last;
  assign out_valid = r_valid;

endmodule
